// File: rtl/ofm_writeback.sv
// OFM write-back: turns 16-lane systolic result beats into two masked 8-element
// DPRAM writes, walking filter, tile and group order across a full layer.
module ofm_writeback #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int INOUT_WIDTH   = 128,
  parameter int OFM_SIZE      = 26,
  parameter int NO_FILTER     = 255,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0]     in_data,
  output logic                                      ofm_wr_en,
  output logic [ADDR_WIDTH-1:0]                     ofm_wr_addr,
  output logic [INOUT_WIDTH-1:0]                    ofm_wr_data,
  output logic [INOUT_WIDTH/(2*DATA_WIDTH)-1:0]     ofm_wr_mask,
  output logic                                      done
);

  localparam int LANE_W   = 2 * DATA_WIDTH;
  localparam int WR_LANES = INOUT_WIDTH / LANE_W;
  localparam int IN_W     = SYSTOLIC_SIZE * LANE_W;
  localparam int NTPL     = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int NO_GROUP = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;

  localparam int FW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int GW = $clog2(NO_GROUP + 1);
  localparam int RW = $clog2(OFM_SIZE + 1);
  localparam int CW = $clog2(NTPL + 1);

  localparam logic [FW-1:0] FILT_LAST  = FW'(SYSTOLIC_SIZE - 1);
  localparam logic [GW-1:0] GROUP_LAST = GW'(NO_GROUP - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(OFM_SIZE - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(NTPL - 1);

  localparam logic [ADDR_WIDTH-1:0] PLANE_A = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OFM_A   = ADDR_WIDTH'(OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] SYS_A   = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] HALF_A  = ADDR_WIDTH'(WR_LANES);
  localparam logic [ADDR_WIDTH-1:0] NOF_A   = ADDR_WIDTH'(NO_FILTER);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             state_r, state_nxt_s;
  logic [FW-1:0]          filt_r, filt_nxt_s;
  logic [GW-1:0]          group_r, group_nxt_s;
  logic [RW-1:0]          row_r, row_nxt_s;
  logic [CW-1:0]          col_r, col_nxt_s;
  logic [INOUT_WIDTH-1:0] hi_data_r, hi_data_nxt_s;

  logic                   in_ready_r, ready_nxt_s;
  logic                   wr_en_r, wr_en_nxt_s;
  logic [ADDR_WIDTH-1:0]  wr_addr_r, wr_addr_nxt_s;
  logic [INOUT_WIDTH-1:0] wr_data_r, wr_data_nxt_s;
  logic [WR_LANES-1:0]    wr_mask_r, wr_mask_nxt_s;
  logic                   done_r, done_nxt_s;

  logic [ADDR_WIDTH-1:0]  filter_s;
  logic [ADDR_WIDTH-1:0]  col_base_s;
  logic [ADDR_WIDTH-1:0]  base_addr_s;
  logic                   filt_ok_s;
  logic                   last_beat_s;
  logic [WR_LANES-1:0]    mask_lo_s;
  logic [WR_LANES-1:0]    mask_hi_s;

  assign filter_s    = ADDR_WIDTH'(group_r) * SYS_A + ADDR_WIDTH'(filt_r);
  assign col_base_s  = ADDR_WIDTH'(col_r) * SYS_A;
  assign base_addr_s = filter_s * PLANE_A + ADDR_WIDTH'(row_r) * OFM_A + col_base_s;
  assign filt_ok_s   = (filter_s < NOF_A);
  assign last_beat_s = (group_r == GROUP_LAST) && (row_r == ROW_LAST) &&
                       (col_r == COL_LAST) && (filt_r == FILT_LAST);

  // Lane masks: drop columns past the feature-map edge and padded filters.
  always_comb begin
    mask_lo_s = {WR_LANES{1'b0}};
    mask_hi_s = {WR_LANES{1'b0}};
    for (int j = 0; j < WR_LANES; j++) begin
      mask_lo_s[j] = filt_ok_s && ((col_base_s + ADDR_WIDTH'(j)) < OFM_A);
      mask_hi_s[j] = filt_ok_s && ((col_base_s + HALF_A + ADDR_WIDTH'(j)) < OFM_A);
    end
  end

  // Next-state, counter and next-output logic; outputs are registered so each
  // state's write appears in the cycle that state is occupied.
  always_comb begin
    state_nxt_s   = state_r;
    filt_nxt_s    = filt_r;
    group_nxt_s   = group_r;
    row_nxt_s     = row_r;
    col_nxt_s     = col_r;
    hi_data_nxt_s = hi_data_r;
    ready_nxt_s   = 1'b0;
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = {ADDR_WIDTH{1'b0}};
    wr_data_nxt_s = {INOUT_WIDTH{1'b0}};
    wr_mask_nxt_s = {WR_LANES{1'b0}};
    done_nxt_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          filt_nxt_s  = {FW{1'b0}};
          group_nxt_s = {GW{1'b0}};
          row_nxt_s   = {RW{1'b0}};
          col_nxt_s   = {CW{1'b0}};
          state_nxt_s = S_WAIT;
          ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready_r) begin
          hi_data_nxt_s = in_data[IN_W-1:INOUT_WIDTH];
          state_nxt_s   = S_WR_LO;
          if (|mask_lo_s) begin
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = base_addr_s;
            wr_data_nxt_s = in_data[INOUT_WIDTH-1:0];
            wr_mask_nxt_s = mask_lo_s;
          end else begin
            wr_en_nxt_s = 1'b0;
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      S_WR_LO: begin
        state_nxt_s = S_WR_HI;
        if (|mask_hi_s) begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = base_addr_s + HALF_A;
          wr_data_nxt_s = hi_data_r;
          wr_mask_nxt_s = mask_hi_s;
        end else begin
          wr_en_nxt_s = 1'b0;
        end
      end
      S_WR_HI: begin
        // Filter index is innermost, then tile column, tile row, then group.
        if (filt_r == FILT_LAST) begin
          filt_nxt_s = {FW{1'b0}};
          if (col_r == COL_LAST) begin
            col_nxt_s = {CW{1'b0}};
            if (row_r == ROW_LAST) begin
              row_nxt_s   = {RW{1'b0}};
              group_nxt_s = group_r + {{(GW-1){1'b0}}, 1'b1};
            end else begin
              row_nxt_s = row_r + {{(RW-1){1'b0}}, 1'b1};
            end
          end else begin
            col_nxt_s = col_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          filt_nxt_s = filt_r + {{(FW-1){1'b0}}, 1'b1};
        end
        if (last_beat_s) begin
          state_nxt_s = S_DONE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
          ready_nxt_s = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      filt_r     <= {FW{1'b0}};
      group_r    <= {GW{1'b0}};
      row_r      <= {RW{1'b0}};
      col_r      <= {CW{1'b0}};
      hi_data_r  <= {INOUT_WIDTH{1'b0}};
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {INOUT_WIDTH{1'b0}};
      wr_mask_r  <= {WR_LANES{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      filt_r     <= filt_nxt_s;
      group_r    <= group_nxt_s;
      row_r      <= row_nxt_s;
      col_r      <= col_nxt_s;
      hi_data_r  <= hi_data_nxt_s;
      in_ready_r <= ready_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
      wr_addr_r  <= wr_addr_nxt_s;
      wr_data_r  <= wr_data_nxt_s;
      wr_mask_r  <= wr_mask_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign ofm_wr_en   = wr_en_r;
  assign ofm_wr_addr = wr_addr_r;
  assign ofm_wr_data = wr_data_r;
  assign ofm_wr_mask = wr_mask_r;
  assign done        = done_r;

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: vector table of address/mask expectations
// over a full layer, golden-image tracking, and reset / start-pulse sequences.
module tb_ofm_writeback;

  localparam int NELEM = 172380;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         ofm_wr_en;
  logic [19:0]  ofm_wr_addr;
  logic [127:0] ofm_wr_data;
  logic [7:0]   ofm_wr_mask;
  logic         done;

  ofm_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .ofm_wr_en(ofm_wr_en),
    .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data),
    .ofm_wr_mask(ofm_wr_mask), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         beat;
    bit         lo_en;
    int         lo_addr;
    logic [7:0] lo_mask;
    bit         hi_en;
    int         hi_addr;
    logic [7:0] hi_mask;
  } vec_t;

  vec_t vecs [11];

  int checks = 0;
  int failures = 0;
  int nwritten, err_dup, err_range, err_data, err_zero, gap_err, ready_err;
  bit written [0:NELEM-1];

  logic         lo_en, hi_en;
  logic [19:0]  lo_addr, hi_addr;
  logic [7:0]   lo_mask, hi_mask;
  logic [127:0] lo_data, hi_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] golden(input int f, input int y, input int x);
    int v;
    v = x + 1 + y * 40 + f * 1100;
    return v[15:0];
  endfunction

  function automatic logic [255:0] make_beat(input int b);
    logic [255:0] d;
    int g, t, fi, f, row, cb;
    g = b / 832; t = (b / 16) % 52; fi = b % 16;
    f = g * 16 + fi; row = t / 2; cb = (t % 2) * 16;
    for (int k = 0; k < 16; k++) d[16*k +: 16] = golden(f, row, cb + k);
    return d;
  endfunction

  task automatic process_half(input logic en, input logic [19:0] addr,
                              input logic [7:0] mask, input logic [127:0] data);
    int a, f, y, x;
    if (!en) begin
      if (addr != 20'd0 || mask != 8'd0 || data != 128'd0) err_zero++;
    end else begin
      if (mask == 8'd0) err_zero++;
      for (int j = 0; j < 8; j++) begin
        if (mask[j]) begin
          a = int'(addr) + j;
          if (a >= NELEM) err_range++;
          else begin
            if (written[a]) err_dup++;
            written[a] = 1'b1;
            nwritten++;
            f = a / 676; y = (a % 676) / 26; x = a % 26;
            if (f >= 255) err_range++;
            if (data[16*j +: 16] !== golden(f, y, x)) err_data++;
          end
        end
      end
    end
  endtask

  task automatic run_beat(input int b);
    int waits;
    in_data = make_beat(b);
    waits = 0;
    while (!in_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout beat=%0d actual=0 required=1", b);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "in_ready timeout");
    end
    start = 1'b0;
    if (waits != 1) gap_err++;
    @(negedge clk);
    lo_en = ofm_wr_en; lo_addr = ofm_wr_addr; lo_mask = ofm_wr_mask; lo_data = ofm_wr_data;
    if (in_ready) ready_err++;
    @(negedge clk);
    hi_en = ofm_wr_en; hi_addr = ofm_wr_addr; hi_mask = ofm_wr_mask; hi_data = ofm_wr_data;
    if (in_ready) ready_err++;
    process_half(lo_en, lo_addr, lo_mask, lo_data);
    process_half(hi_en, hi_addr, hi_mask, hi_data);
  endtask

  task automatic clear_tracking();
    foreach (written[i]) written[i] = 1'b0;
    nwritten = 0; err_dup = 0; err_range = 0; err_data = 0; err_zero = 0;
  endtask

  initial begin
    int vi;
    vecs[0]  = '{0,     1'b1, 0,      8'hFF, 1'b1, 8,      8'hFF};
    vecs[1]  = '{1,     1'b1, 676,    8'hFF, 1'b1, 684,    8'hFF};
    vecs[2]  = '{16,    1'b1, 16,     8'hFF, 1'b1, 24,     8'h03};
    vecs[3]  = '{17,    1'b1, 692,    8'hFF, 1'b1, 700,    8'h03};
    vecs[4]  = '{32,    1'b1, 26,     8'hFF, 1'b1, 34,     8'hFF};
    vecs[5]  = '{816,   1'b1, 666,    8'hFF, 1'b1, 674,    8'h03};
    vecs[6]  = '{832,   1'b1, 10816,  8'hFF, 1'b1, 10824,  8'hFF};
    vecs[7]  = '{12494, 1'b1, 171704, 8'hFF, 1'b1, 171712, 8'hFF};
    vecs[8]  = '{12495, 1'b0, 0,      8'h00, 1'b0, 0,      8'h00};
    vecs[9]  = '{13310, 1'b1, 172370, 8'hFF, 1'b1, 172378, 8'h03};
    vecs[10] = '{13311, 1'b0, 0,      8'h00, 1'b0, 0,      8'h00};

    clk = 1'b0; rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 256'd0;
    gap_err = 0; ready_err = 0;
    clear_tracking();

    repeat (2) @(negedge clk);
    check("reset_outputs", {in_ready, ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_wr_mask, done}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores in_valid
    in_valid = 1'b1;
    in_data = make_beat(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle_ignore_%0d", i), {in_ready, ofm_wr_en, done}, 256'd0);
    end

    // Partial layer, then reset during WR_LO of beat 100
    start = 1'b1;
    for (int b = 0; b < 100; b++) run_beat(b);
    in_data = make_beat(100);
    @(negedge clk);
    check("beat100_ready", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    check("beat100_wr_lo_en", {255'd0, ofm_wr_en}, 256'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {in_ready, ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_wr_mask, done}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle_%0d", i), {in_ready, ofm_wr_en, done}, 256'd0);
    end

    // Full layer from restart
    clear_tracking();
    vi = 0;
    start = 1'b1;
    for (int b = 0; b < 13312; b++) begin
      run_beat(b);
      if (b == 0) begin
        check("beat0_lo_data", {128'd0, lo_data}, {128'd0, 128'h0008000700060005000400030002_0001});
        check("beat0_hi_data", {128'd0, hi_data}, {128'd0, 128'h0010000f000e000d000c000b000a_0009});
      end
      if (vi < 11 && vecs[vi].beat == b) begin
        check($sformatf("vec_lo_beat%0d", b), {227'd0, lo_en, lo_addr, lo_mask},
              {227'd0, vecs[vi].lo_en, vecs[vi].lo_addr[19:0], vecs[vi].lo_mask});
        check($sformatf("vec_hi_beat%0d", b), {227'd0, hi_en, hi_addr, hi_mask},
              {227'd0, vecs[vi].hi_en, vecs[vi].hi_addr[19:0], vecs[vi].hi_mask});
        vi++;
      end
      if (b == 5000) start = 1'b1;
    end

    @(negedge clk);
    check("done_pulse", {254'd0, done, in_ready}, {254'd0, 1'b1, 1'b0});
    @(negedge clk);
    check("done_cleared", {253'd0, done, in_ready, ofm_wr_en}, 256'd0);

    check("vectors_applied", vi, 11);
    check("elements_written", nwritten, NELEM);
    check("duplicate_writes", err_dup, 0);
    check("out_of_range_writes", err_range, 0);
    check("golden_image_data", err_data, 0);
    check("idle_outputs_zero", err_zero, 0);
    check("beat_gap_3_cycles", gap_err, 0);
    check("ready_low_in_writes", ready_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
